// File: rtl/f_pc_unit_pkg.sv
// rtl/f_pc_unit_pkg.sv - shared fetch-stage constants, F/D record type and fetch address check
package f_pc_unit_pkg;

    localparam logic [31:0] RESET_PC   = 32'h0000_3000;
    localparam logic [31:0] HANDLER_PC = 32'h0000_4180;
    localparam logic [31:0] IM_LO      = 32'h0000_3000;
    localparam logic [31:0] IM_HI      = 32'h0000_6FFC;
    localparam logic [4:0]  EXC_NONE   = 5'd0;
    localparam logic [4:0]  EXC_ADEL   = 5'd4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [4:0]  exc_code;
        logic        bd;
    } fd_t;

    localparam fd_t FD_RESET = '{pc: RESET_PC, instr: 32'h0, exc_code: EXC_NONE, bd: 1'b0};
    localparam fd_t FD_FLUSH = '{pc: HANDLER_PC, instr: 32'h0, exc_code: EXC_NONE, bd: 1'b0};

    // Misaligned or outside instruction memory -> AdEL; no wrap handling, D owns npc arithmetic.
    function automatic logic [4:0] fetch_exc(input logic [31:0] addr);
        return (addr[1:0] != 2'b00 || addr < IM_LO || addr > IM_HI) ? EXC_ADEL : EXC_NONE;
    endfunction

endpackage

// File: rtl/f_pc_unit_if.sv
// rtl/f_pc_unit_if.sv - instruction-memory fetch bus between F stage and IM
interface f_pc_unit_if;

    logic [31:0] i_inst_addr;
    logic [31:0] i_inst_rdata;

    modport master (output i_inst_addr, input  i_inst_rdata);
    modport slave  (input  i_inst_addr, output i_inst_rdata);

endinterface

// File: rtl/f_pc_unit_f_d_reg.sv
// rtl/f_pc_unit_f_d_reg.sv - F/D pipeline register with stall hold and flush
module f_pc_unit_f_d_reg
    import f_pc_unit_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic stall,
    input  logic flush,
    input  fd_t  fd_d,
    output fd_t  fd_q
);

    // Flush outranks stall so an exception request is never swallowed by a hazard.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fd_q <= FD_RESET;
        end else if (flush) begin
            fd_q <= FD_FLUSH;
        end else if (!stall) begin
            fd_q <= fd_d;
        end
    end

endmodule

// File: rtl/f_pc_unit.sv
// rtl/f_pc_unit.sv - F stage: PC register, fetch address mux, AdEL check, F/D register
module f_pc_unit
    import f_pc_unit_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] npc,
    input  logic        stall,
    input  logic        req,
    input  logic        d_eret,
    input  logic [31:0] epc,
    input  logic        f_bd,
    f_pc_unit_if.master im,
    output logic [31:0] d_pc,
    output logic [31:0] d_instr,
    output logic [4:0]  d_exc_code,
    output logic        d_bd
);

    logic [31:0] pc_q;
    logic [31:0] f_addr;
    logic [4:0]  f_exc;
    fd_t         fd_d;
    fd_t         fd_q;

    // eret fetches EPC directly this cycle; D supplies npc = epc + 4 so the next fetch lines up.
    assign f_addr         = d_eret ? epc : pc_q;
    assign im.i_inst_addr = f_addr;
    assign f_exc          = fetch_exc(f_addr);

    always_comb begin
        fd_d.pc       = f_addr;
        fd_d.instr    = (f_exc != EXC_NONE) ? 32'h0 : im.i_inst_rdata;
        fd_d.exc_code = f_exc;
        fd_d.bd       = f_bd;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q <= RESET_PC;
        end else if (req) begin
            pc_q <= HANDLER_PC;
        end else if (!stall) begin
            pc_q <= npc;
        end
    end

    f_pc_unit_f_d_reg u_f_d_reg (
        .clk   (clk),
        .reset (reset),
        .stall (stall),
        .flush (req),
        .fd_d  (fd_d),
        .fd_q  (fd_q)
    );

    assign d_pc       = fd_q.pc;
    assign d_instr    = fd_q.instr;
    assign d_exc_code = fd_q.exc_code;
    assign d_bd       = fd_q.bd;

endmodule

// File: tb/tb_f_pc_unit.sv
// tb/tb_f_pc_unit.sv - self-checking bench for f_pc_unit against a behavioural fetch model
module tb_f_pc_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] npc;
    logic        stall;
    logic        req;
    logic        d_eret;
    logic [31:0] epc;
    logic        f_bd;
    logic [31:0] d_pc;
    logic [31:0] d_instr;
    logic [4:0]  d_exc_code;
    logic        d_bd;

    int tests = 0;
    int fails = 0;

    // Behavioural model state: architectural PC and the record visible in D.
    logic [31:0] m_pc, m_dpc, m_dinstr;
    logic [4:0]  m_dexc;
    logic        m_dbd;

    f_pc_unit_if imif ();

    always #5 clk = ~clk;

    // Instruction memory contents: never zero for any address, so forced-zero is distinguishable.
    function automatic logic [31:0] memw(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1234_5678;
    endfunction

    assign imif.i_inst_rdata = memw(imif.i_inst_addr);

    f_pc_unit dut (
        .clk        (clk),
        .reset      (reset),
        .npc        (npc),
        .stall      (stall),
        .req        (req),
        .d_eret     (d_eret),
        .epc        (epc),
        .f_bd       (f_bd),
        .im         (imif.master),
        .d_pc       (d_pc),
        .d_instr    (d_instr),
        .d_exc_code (d_exc_code),
        .d_bd       (d_bd)
    );

    function automatic logic [31:0] exp_addr();
        return d_eret ? epc : m_pc;
    endfunction

    task automatic model_reset();
        m_pc = 32'h3000; m_dpc = 32'h3000; m_dinstr = 32'h0; m_dexc = 5'd0; m_dbd = 1'b0;
    endtask

    // Apply one cycle of inputs, clock it, and advance the model from the fetch rules.
    task automatic step(input logic [31:0] n, input logic s, input logic r, input logic e,
                        input logic [31:0] ep, input logic bd);
        logic [31:0] a, ins;
        logic [4:0]  ex;
        npc = n; stall = s; req = r; d_eret = e; epc = ep; f_bd = bd;
        #1;
        a   = e ? ep : m_pc;
        ex  = (a % 4 != 0 || a < 32'h3000 || a > 32'h6FFC) ? 5'd4 : 5'd0;
        ins = (ex != 0) ? 32'h0 : memw(a);
        @(posedge clk); #1;
        if (r) begin
            m_pc = 32'h4180; m_dpc = 32'h4180; m_dinstr = 0; m_dexc = 0; m_dbd = 0;
        end else if (!s) begin
            m_pc = n; m_dpc = a; m_dinstr = ins; m_dexc = ex; m_dbd = bd;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; npc = 32'h3004; stall = 0; req = 0; d_eret = 0; epc = 0; f_bd = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if ({d_pc, d_instr, d_exc_code, d_bd} !== {32'h3000, 32'h0, 5'd0, 1'b0}) begin
            fails++; $display("FAIL reset_fd: got %h/%h/%0d/%b want 3000/0/0/0", d_pc, d_instr, d_exc_code, d_bd);
        end
        tests++;
        if (imif.i_inst_addr !== 32'h3000) begin
            fails++; $display("FAIL reset_addr: got %h want 00003000", imif.i_inst_addr);
        end
        reset = 1'b1;
    endtask

    task automatic test_sequential();
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (imif.i_inst_addr !== 32'h3000 + 4 * i) begin
                fails++; $display("FAIL seq_addr%0d: got %h want %h", i, imif.i_inst_addr, 32'h3000 + 4 * i);
            end
            step(32'h3004 + 4 * i, 0, 0, 0, 0, i[0]);
            tests++;
            if ({d_pc, d_instr, d_bd} !== {32'h3000 + 4 * i, memw(32'h3000 + 4 * i), i[0]}) begin
                fails++; $display("FAIL seq_fd%0d: got %h/%h/%b want %h", i, d_pc, d_instr, d_bd, 32'h3000 + 4 * i);
            end
        end
    endtask

    task automatic test_stall();
        logic [31:0] pc0, dpc0, di0;
        pc0 = m_pc; dpc0 = m_dpc; di0 = m_dinstr;
        for (int i = 0; i < 2; i++) begin
            step(pc0 + 32'h40, 1, 0, 0, 0, 1);
            tests++;
            if ({imif.i_inst_addr, d_pc, d_instr} !== {pc0, dpc0, di0}) begin
                fails++; $display("FAIL stall_hold%0d: got %h/%h/%h want %h/%h/%h", i,
                                  imif.i_inst_addr, d_pc, d_instr, pc0, dpc0, di0);
            end
        end
        step(pc0 + 4, 0, 0, 0, 0, 0);
        tests++;
        if ({imif.i_inst_addr, d_pc} !== {pc0 + 32'd4, pc0}) begin
            fails++; $display("FAIL stall_resume: got %h/%h want %h/%h", imif.i_inst_addr, d_pc, pc0 + 4, pc0);
        end
    endtask

    task automatic test_range();
        logic [31:0] addrs [4];
        logic [4:0]  excs  [4];
        addrs = '{32'h3002, 32'h7000, 32'h2FFC, 32'h6FFC};
        excs  = '{5'd4, 5'd4, 5'd4, 5'd0};
        for (int i = 0; i < 4; i++) begin
            step(addrs[i], 0, 0, 0, 0, 0);
            tests++;
            if (imif.i_inst_addr !== addrs[i]) begin
                fails++; $display("FAIL range_addr%0d: got %h want %h", i, imif.i_inst_addr, addrs[i]);
            end
            step(32'h3100, 0, 0, 0, 0, 0);
            tests++;
            if ({d_exc_code, d_pc, d_instr} !== {excs[i], addrs[i], (excs[i] != 0) ? 32'h0 : memw(addrs[i])}) begin
                fails++; $display("FAIL range_exc%0d: got %0d/%h/%h want %0d/%h", i, d_exc_code, d_pc, d_instr,
                                  excs[i], addrs[i]);
            end
        end
    endtask

    task automatic test_req();
        step(32'h3200, 1, 1, 0, 0, 1);
        tests++;
        if ({imif.i_inst_addr, d_pc, d_instr, d_exc_code, d_bd} !== {32'h4180, 32'h4180, 32'h0, 5'd0, 1'b0}) begin
            fails++; $display("FAIL req_stall: got %h/%h/%h/%0d/%b want 4180/4180/0/0/0",
                              imif.i_inst_addr, d_pc, d_instr, d_exc_code, d_bd);
        end
        step(32'h4184, 0, 0, 0, 0, 0);
        step(32'h3300, 0, 1, 1, 32'h3040, 1);
        d_eret = 0; #1;
        tests++;
        if ({imif.i_inst_addr, d_pc, d_instr} !== {32'h4180, 32'h4180, 32'h0}) begin
            fails++; $display("FAIL req_eret: got %h/%h/%h want 4180/4180/0", imif.i_inst_addr, d_pc, d_instr);
        end
    endtask

    task automatic test_eret();
        npc = 32'h3044; d_eret = 1; epc = 32'h3040; stall = 0; req = 0; #1;
        tests++;
        if (imif.i_inst_addr !== 32'h3040) begin
            fails++; $display("FAIL eret_addr: got %h want 00003040", imif.i_inst_addr);
        end
        step(32'h3044, 0, 0, 1, 32'h3040, 0);
        d_eret = 0; #1;
        tests++;
        if ({imif.i_inst_addr, d_pc, d_instr} !== {32'h3044, 32'h3040, memw(32'h3040)}) begin
            fails++; $display("FAIL eret_next: got %h/%h/%h want 3044/3040", imif.i_inst_addr, d_pc, d_instr);
        end
        step(32'h3500, 1, 0, 1, 32'h3080, 0);
        tests++;
        if ({imif.i_inst_addr, d_pc} !== {32'h3080, 32'h3040}) begin
            fails++; $display("FAIL eret_stall: got %h/%h want 3080/3040", imif.i_inst_addr, d_pc);
        end
        d_eret = 0; #1;
        tests++;
        if (imif.i_inst_addr !== 32'h3044) begin
            fails++; $display("FAIL eret_stall_pc: got %h want 00003044", imif.i_inst_addr);
        end
    endtask

    task automatic test_random();
        logic [31:0] n;
        int bad = 0;
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 9))
                0:       n = $urandom;
                1:       n = 32'hFFFF_FFFC;
                2:       n = 32'h3000 + ($urandom_range(0, 32'h1FFF) << 1);
                default: n = 32'h3000 + ($urandom_range(0, 32'hFFF) << 2);
            endcase
            step(n, $urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0,
                 ($urandom_range(0, 3) == 0) ? $urandom : 32'h3000 + ($urandom_range(0, 32'hFFF) << 2),
                 1'($urandom));
            tests++;
            if ({imif.i_inst_addr, d_pc, d_instr, d_exc_code, d_bd} !== {exp_addr(), m_dpc, m_dinstr, m_dexc, m_dbd}) begin
                fails++;
                if (bad++ < 5)
                    $display("FAIL random%0d: got %h %h/%h/%0d/%b want %h %h/%h/%0d/%b", i, imif.i_inst_addr,
                             d_pc, d_instr, d_exc_code, d_bd, exp_addr(), m_dpc, m_dinstr, m_dexc, m_dbd);
            end
        end
    endtask

    task automatic test_async_reset();
        step(32'h3404, 0, 0, 0, 0, 1);
        step(32'h3408, 0, 0, 0, 0, 1);
        d_eret = 0; #2;
        reset = 1'b0; #1;
        model_reset();
        tests++;
        if ({imif.i_inst_addr, d_pc, d_instr, d_exc_code, d_bd} !== {32'h3000, 32'h3000, 32'h0, 5'd0, 1'b0}) begin
            fails++; $display("FAIL async_reset: got %h %h/%h/%0d/%b want 3000 3000/0/0/0",
                              imif.i_inst_addr, d_pc, d_instr, d_exc_code, d_bd);
        end
        #1 reset = 1'b1;
        step(32'h3004, 0, 0, 0, 0, 0);
        tests++;
        if ({imif.i_inst_addr, d_pc, d_instr} !== {32'h3004, 32'h3000, memw(32'h3000)}) begin
            fails++; $display("FAIL reset_release: got %h/%h/%h want 3004/3000", imif.i_inst_addr, d_pc, d_instr);
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_range();
        test_req();
        test_eret();
        test_random();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
